// File: rtl/pipeline_pkg.sv
// Shared encodings for the RV32I pipeline hazard controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pipeline_pkg;

  localparam int REG_W = 5;

  // Forwarding mux selects for the E-stage ALU operands
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_W  = 2'b01;  // ResultW
  localparam logic [1:0] FWD_M  = 2'b10;  // ALUResultM

  // resultSrc encoding that marks a load
  localparam logic [1:0] RES_LOAD = 2'b01;

  // Data-memory wait FSM states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } mem_state_e;

  // Per-stage hold/bubble controls
  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushD;
    logic flushE;
    logic flushW;
  } hz_ctrl_t;

  // Operand bypass select: the younger M result beats W; x0 never forwards
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                         input logic [REG_W-1:0] rd_m,
                                         input logic             wr_m,
                                         input logic [REG_W-1:0] rd_w,
                                         input logic             wr_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// Latency: n/a (wires only).
// Backpressure: dmemReadyM is the memory's completion handshake for dmemReqM.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned PERF_W = 32
);
  import pipeline_pkg::*;

  logic [REG_W-1:0]  rs1D;
  logic [REG_W-1:0]  rs2D;
  logic [REG_W-1:0]  rs1E;
  logic [REG_W-1:0]  rs2E;
  logic [REG_W-1:0]  rdE;
  logic [1:0]        resultSrcE;
  logic              pcSrcE;
  logic [REG_W-1:0]  rdM;
  logic              regWriteM;
  logic              memAccessM;
  logic [REG_W-1:0]  rdW;
  logic              regWriteW;
  logic              dmemReadyM;

  logic              dmemReqM;
  logic [1:0]        forwardAE;
  logic [1:0]        forwardBE;
  logic              stallF;
  logic              stallD;
  logic              stallE;
  logic              stallM;
  logic              flushD;
  logic              flushE;
  logic              flushW;
  logic              memFault;
  logic [PERF_W-1:0] stallCycles;

  // Datapath side: supplies stage info, consumes controls
  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, resultSrcE, pcSrcE,
           rdM, regWriteM, memAccessM, rdW, regWriteW, dmemReadyM,
    input  dmemReqM, forwardAE, forwardBE, stallF, stallD, stallE, stallM,
           flushD, flushE, flushW, memFault, stallCycles
  );

  // Hazard controller side
  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, resultSrcE, pcSrcE,
           rdM, regWriteM, memAccessM, rdW, regWriteW, dmemReadyM,
    output dmemReqM, forwardAE, forwardBE, stallF, stallD, stallE, stallM,
           flushD, flushE, flushW, memFault, stallCycles
  );

endinterface

// File: rtl/mem_wait_fsm.sv
// Freezes the pipeline while a data-memory access in M is outstanding; times out to a sticky fault.
// Latency: memStall/dmemReqM are combinational from state and inputs; state advances each clk.
// Backpressure: waits on dmemReadyM for up to MEM_TIMEOUT MEM_WAIT cycles, then stalls forever.
module mem_wait_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic memAccessM,
  input  logic dmemReadyM,
  output logic memStall,
  output logic dmemReqM,
  output logic memFault
);
  import pipeline_pkg::*;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  mem_state_e state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  // State and wait-counter registers; reset drops straight back to RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state, request and stall decode
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    memStall   = 1'b0;
    dmemReqM   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        dmemReqM = memAccessM;
        // A ready-in-the-same-cycle access completes without a stall
        if (memAccessM && !dmemReadyM) begin
          memStall   = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        // M is frozen, so the request is held regardless of memAccessM
        dmemReqM = 1'b1;
        if (dmemReadyM) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          memStall = 1'b1;
          if (wait_cnt_q == TIMEOUT_C) begin
            state_d = ST_FAULT;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      ST_FAULT: begin
        memStall = 1'b1;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  assign memFault = (state_q == ST_FAULT);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Forwarding, load-use, control-hazard and memory-wait stall scheduling for the 5-stage pipeline.
// Latency: all controls combinational; only the memory FSM and stall counter are registered.
// Backpressure: a pending data-memory access freezes F..M and bubbles W until dmemReadyM.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned PERF_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);
  import pipeline_pkg::*;

  logic              mem_stall;
  logic              load_use;
  hz_ctrl_t          ctrl;
  logic [PERF_W-1:0] stall_cnt_q;

  mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .clk        (clk),
    .rst        (rst),
    .memAccessM (hz.memAccessM),
    .dmemReadyM (hz.dmemReadyM),
    .memStall   (mem_stall),
    .dmemReqM   (hz.dmemReqM),
    .memFault   (hz.memFault)
  );

  assign hz.forwardAE = fwd_sel(hz.rs1E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW);
  assign hz.forwardBE = fwd_sel(hz.rs2E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW);

  // Stall/flush priority: memory freeze > redirect > load-use bubble
  always_comb begin
    ctrl     = '0;
    load_use = 1'b0;
    if (mem_stall) begin
      // Everything holds; a pending redirect stays in E and fires on release
      ctrl.stallF = 1'b1;
      ctrl.stallD = 1'b1;
      ctrl.stallE = 1'b1;
      ctrl.stallM = 1'b1;
      ctrl.flushW = 1'b1;
    end else begin
      load_use = (hz.resultSrcE == RES_LOAD) && (hz.rdE != '0) &&
                 ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
      if (hz.pcSrcE) begin
        // Redirect kills the dependent instruction anyway, so F must load the new PC
        ctrl.flushD = 1'b1;
        ctrl.flushE = 1'b1;
      end else if (load_use) begin
        ctrl.stallF = 1'b1;
        ctrl.stallD = 1'b1;
        ctrl.flushE = 1'b1;
      end
    end
  end

  assign hz.stallF = ctrl.stallF;
  assign hz.stallD = ctrl.stallD;
  assign hz.stallE = ctrl.stallE;
  assign hz.stallM = ctrl.stallM;
  assign hz.flushD = ctrl.flushD;
  assign hz.flushE = ctrl.flushE;
  assign hz.flushW = ctrl.flushW;

  // Saturating count of cycles in which fetch is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (ctrl.stallF && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign hz.stallCycles = stall_cnt_q;

endmodule
